bsg_flow_counter_mc: RTL and testbench
======================================

BSG_FLOW_COUNTER_MC -- requirements
Module: bsg_flow_counter_mc

Interface
REQ-001 SHALL have parameter els_p, default 256: per-channel capacity in elements.
REQ-002 SHALL have parameter channels_p, default 4: number of independent flow channels.
REQ-003 SHALL have parameter max_step_p, default 2: maximum dequeue-completion count per channel per cycle.
REQ-004 SHALL have parameter count_free_p, default 1: 1 = count free credits, 0 = count occupied elements.
REQ-005 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_i, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port v_i, input, channels_p: producer valid per channel.
REQ-008 SHALL have port ready_i, input, channels_p: consumer ready per channel; enqueue[c] = v_i[c] & ready_i[c].
REQ-009 SHALL have port yumi_cnt_i, input, channels_p x cw, where cw = clog2(max_step_p+1): elements retired per channel this cycle.
REQ-010 SHALL have port count_o, input-independent output, channels_p x lg_els, where lg_els = clog2(els_p+1): registered count per channel.
REQ-011 SHALL have port full_o, output, channels_p: no free credits; all elements occupied.
REQ-012 SHALL have port empty_o, output, channels_p: no elements occupied; all credits free.
REQ-013 SHALL have port error_o, output, channels_p: sticky overflow/underflow flag per channel.

Function
REQ-014 SHALL keep one independent occupancy counter per channel; channels never interact.
REQ-015 SHALL, per cycle, compute used_next = used + enqueue[c] - yumi_cnt_i[c] at lg_els+2 bits, signed.
REQ-016 SHALL present count_o[c] = els_p - used when count_free_p=1, else used; count_o is a flop output, one-cycle latency from events.
REQ-017 SHALL treat simultaneous enqueue and yumi in the same cycle as a net change; enqueue=1 and yumi_cnt=1 leave count unchanged.
REQ-018 SHALL drive full_o[c] = (used == els_p) and empty_o[c] = (used == 0), derived combinationally from registered state only.
REQ-019 SHALL, when used_next > els_p (overflow), clamp used to els_p and set error_o[c].
REQ-020 SHALL, when used_next < 0 (underflow), clamp used to 0 and set error_o[c].
REQ-021 SHALL, once set, hold error_o[c] until reset; it is not cleared by subsequent legal traffic.
REQ-022 SHALL accept yumi_cnt_i[c] values up to max_step_p; a value above max_step_p SHALL set error_o[c] and leave the count unchanged.
REQ-023 SHALL allow els_p values that are not powers of two, with no wrap-around at 2^lg_els.

Reset
REQ-024 SHALL, while reset_i is high at a clock edge, set used = 0 for all channels; count_o then reads els_p (free mode) or 0 (used mode).
REQ-025 SHALL, on reset, clear error_o to 0, set empty_o to all ones and full_o to all zeros.
REQ-026 SHALL let reset asserted mid-traffic take priority over any same-cycle enqueue or yumi.

Structure
REQ-027 SHALL place the width helpers (lg_els, cw) and a channel-status struct {count, full, empty, error} in a shared package, bsg_flow_counter_pkg.
REQ-028 SHALL instantiate one sub-module per channel, bsg_counter_up_down_sat, which holds the saturating counter and error logic, in a generate loop.

Verification
All scenarios use els_p=8, channels_p=2, max_step_p=2, count_free_p=1 unless noted.
REQ-029 SHALL cover reset: after reset -> count_o={8,8}, empty_o=2'b11, full_o=0, error_o=0.
REQ-030 SHALL cover fill: 8 enqueues on channel 0 -> count_o[0]=0, full_o[0]=1; channel 1 stays at 8.
REQ-031 SHALL cover simultaneous events: at count 5, enqueue plus yumi_cnt=2 -> count 6 next cycle.
REQ-032 SHALL cover overflow: at full, one more enqueue -> count stays 0, error_o[0]=1, and error_o[0] stays 1 after later yumis.
REQ-033 SHALL cover underflow and used mode (count_free_p=0): at used=1, yumi_cnt=2 -> count_o=0, error_o=1; a yumi_cnt of 3 on a clean channel -> error, count unchanged.
REQ-034 SHALL cover reset mid-traffic: reset high with an enqueue in the same cycle -> count_o=8, error_o cleared.

Source files
------------

// File: rtl/bsg_flow_counter_pkg.sv
// Shared width helpers and the per-channel status payload for the flow counter.
package bsg_flow_counter_pkg;

    // Widest count a channel may present (els_p must stay below 2**count_max_w).
    localparam int unsigned count_max_w = 16;

    // Bits needed to hold an occupancy in 0..els inclusive.
    function automatic int unsigned lg_els(input int unsigned els);
        return $clog2(els + 1);
    endfunction

    // Bits needed to hold a per-cycle retire count in 0..max_step inclusive.
    function automatic int unsigned cw(input int unsigned max_step);
        return $clog2(max_step + 1);
    endfunction

    typedef struct packed {
        logic [count_max_w-1:0] count;
        logic                   full;
        logic                   empty;
        logic                   error;
    } chan_status_s;

endpackage

// File: rtl/bsg_flow_counter_mc_if.sv
// Producer/consumer handshake and per-channel status bundle for the flow counter.
interface bsg_flow_counter_mc_if #(
    parameter int unsigned els_p      = 256,
    parameter int unsigned channels_p = 4,
    parameter int unsigned max_step_p = 2
);
    import bsg_flow_counter_pkg::*;

    localparam int unsigned lg_els_lp = lg_els(els_p);
    localparam int unsigned cw_lp     = cw(max_step_p);

    logic [channels_p-1:0]                v_i;
    logic [channels_p-1:0]                ready_i;
    logic [channels_p-1:0][cw_lp-1:0]     yumi_cnt_i;
    logic [channels_p-1:0][lg_els_lp-1:0] count_o;
    logic [channels_p-1:0]                full_o;
    logic [channels_p-1:0]                empty_o;
    logic [channels_p-1:0]                error_o;

    modport master (
        output v_i, ready_i, yumi_cnt_i,
        input  count_o, full_o, empty_o, error_o
    );

    modport slave (
        input  v_i, ready_i, yumi_cnt_i,
        output count_o, full_o, empty_o, error_o
    );

endinterface

// File: rtl/bsg_counter_up_down_sat.sv
// One channel's saturating occupancy counter with sticky overflow/underflow error.
module bsg_counter_up_down_sat
    import bsg_flow_counter_pkg::*;
#(
    parameter int unsigned els_p        = 256,
    parameter int unsigned max_step_p   = 2,
    parameter int unsigned count_free_p = 1
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      up_i,
    input  logic [cw(max_step_p)-1:0] down_i,
    output chan_status_s              status_o
);

    localparam int unsigned lg_lp    = lg_els(els_p);
    localparam int unsigned cw_lp    = cw(max_step_p);
    localparam int unsigned sum_w_lp = lg_lp + 2;

    localparam logic [lg_lp-1:0]       els_lp       = lg_lp'(els_p);
    localparam logic [count_max_w-1:0] count_rst_lp = (count_free_p != 0) ? count_max_w'(els_p)
                                                                          : '0;

    logic [lg_lp-1:0]           used_r;
    logic [lg_lp-1:0]           used_n;
    logic                       error_n;
    logic signed [sum_w_lp-1:0] sum;
    logic                       step_bad;
    chan_status_s               status_r;
    chan_status_s               status_n;

    // Net occupancy change, saturation and error detection; status built from next state.
    always_comb begin
        sum      = $signed(sum_w_lp'(used_r)) + $signed(sum_w_lp'(up_i))
                 - $signed(sum_w_lp'(down_i));
        step_bad = (down_i > cw_lp'(max_step_p));
        used_n   = used_r;
        error_n  = status_r.error;
        status_n = '0;

        if (step_bad) begin
            error_n = 1'b1;
        end else if (sum < 0) begin
            used_n  = '0;
            error_n = 1'b1;
        end else if (sum > $signed(sum_w_lp'(els_p))) begin
            used_n  = els_lp;
            error_n = 1'b1;
        end else begin
            used_n  = lg_lp'(sum);
        end

        status_n.count = (count_free_p != 0) ? count_max_w'(els_lp - used_n)
                                             : count_max_w'(used_n);
        status_n.full  = (used_n == els_lp);
        status_n.empty = (used_n == '0);
        status_n.error = error_n;
    end

    // Occupancy and presented status registers; reset empties the channel.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            used_r         <= '0;
            status_r.count <= count_rst_lp;
            status_r.full  <= 1'b0;
            status_r.empty <= 1'b1;
            status_r.error <= 1'b0;
        end else begin
            used_r   <= used_n;
            status_r <= status_n;
        end
    end

    assign status_o = status_r;

endmodule

// File: rtl/bsg_flow_counter_mc.sv
// Multi-channel flow counter: one independent saturating counter per channel.
module bsg_flow_counter_mc
    import bsg_flow_counter_pkg::*;
#(
    parameter int unsigned els_p        = 256,
    parameter int unsigned channels_p   = 4,
    parameter int unsigned max_step_p   = 2,
    parameter int unsigned count_free_p = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    bsg_flow_counter_mc_if.slave bus
);

    localparam int unsigned lg_els_lp = lg_els(els_p);

    chan_status_s status [channels_p];

    for (genvar c = 0; c < channels_p; c++) begin : g_chan
        logic                   enq;
        logic [count_max_w-1:0] count_unused;

        // A transfer happens only when producer and consumer agree.
        assign enq = bus.v_i[c] & bus.ready_i[c];

        bsg_counter_up_down_sat #(
            .els_p        (els_p),
            .max_step_p   (max_step_p),
            .count_free_p (count_free_p)
        ) u_ctr (
            .clk_i    (clk_i),
            .reset_i  (reset_i),
            .up_i     (enq),
            .down_i   (bus.yumi_cnt_i[c]),
            .status_o (status[c])
        );

        // Upper count bits are always zero for the configured depth.
        assign count_unused    = status[c].count;
        assign bus.count_o[c]  = lg_els_lp'(status[c].count);
        assign bus.full_o[c]   = status[c].full;
        assign bus.empty_o[c]  = status[c].empty;
        assign bus.error_o[c]  = status[c].error;
    end

endmodule

// File: tb/tb_bsg_flow_counter_mc.sv
// Bench for bsg_flow_counter_mc: free-count and used-count instances driven in lockstep.
module tb_bsg_flow_counter_mc;

    localparam int els_lp  = 8;
    localparam int ch_lp   = 2;
    localparam int step_lp = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      v;
    logic [1:0]      ready;
    logic [1:0][1:0] yumi;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: plain occupancy integers and sticky error bits per channel.
    int used [ch_lp];
    bit err  [ch_lp];

    always #5 clk = ~clk;

    bsg_flow_counter_mc_if #(.els_p(els_lp), .channels_p(ch_lp), .max_step_p(step_lp)) bus_f ();
    bsg_flow_counter_mc_if #(.els_p(els_lp), .channels_p(ch_lp), .max_step_p(step_lp)) bus_u ();

    assign bus_f.v_i        = v;
    assign bus_f.ready_i    = ready;
    assign bus_f.yumi_cnt_i = yumi;
    assign bus_u.v_i        = v;
    assign bus_u.ready_i    = ready;
    assign bus_u.yumi_cnt_i = yumi;

    bsg_flow_counter_mc #(
        .els_p(els_lp), .channels_p(ch_lp), .max_step_p(step_lp), .count_free_p(1)
    ) dut_f (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus_f)
    );

    bsg_flow_counter_mc #(
        .els_p(els_lp), .channels_p(ch_lp), .max_step_p(step_lp), .count_free_p(0)
    ) dut_u (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus_u)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] vv, input logic [1:0] rr,
                         input logic [1:0] y0, input logic [1:0] y1);
        reset   = r;
        v       = vv;
        ready   = rr;
        yumi[0] = y0;
        yumi[1] = y1;
    endtask

    // Apply this cycle's events to the model.
    task automatic model_step();
        for (int c = 0; c < ch_lp; c++) begin
            int n;
            if (reset) begin
                used[c] = 0;
                err[c]  = 0;
            end else if (int'(yumi[c]) > step_lp) begin
                err[c] = 1;
            end else begin
                n = used[c] + int'(v[c] & ready[c]) - int'(yumi[c]);
                if (n > els_lp) begin
                    used[c] = els_lp;
                    err[c]  = 1;
                end else if (n < 0) begin
                    used[c] = 0;
                    err[c]  = 1;
                end else begin
                    used[c] = n;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < ch_lp; c++) begin
            check($sformatf("cnt_free%0d", c), int'(bus_f.count_o[c]), els_lp - used[c]);
            check($sformatf("cnt_used%0d", c), int'(bus_u.count_o[c]), used[c]);
            check($sformatf("full_f%0d", c),   int'(bus_f.full_o[c]),  int'(used[c] == els_lp));
            check($sformatf("empty_f%0d", c),  int'(bus_f.empty_o[c]), int'(used[c] == 0));
            check($sformatf("err_f%0d", c),    int'(bus_f.error_o[c]), int'(err[c]));
            check($sformatf("full_u%0d", c),   int'(bus_u.full_o[c]),  int'(used[c] == els_lp));
            check($sformatf("empty_u%0d", c),  int'(bus_u.empty_o[c]), int'(used[c] == 0));
            check($sformatf("err_u%0d", c),    int'(bus_u.error_o[c]), int'(err[c]));
        end
    endtask

    // One clock: model consumes current inputs, outputs checked just after the edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        for (int c = 0; c < ch_lp; c++) begin
            used[c] = 0;
            err[c]  = 0;
        end

        // Reset state
        drive(1'b1, 2'b00, 2'b00, 2'd0, 2'd0);
        cycle();
        cycle();
        check("rst_cnt0",  int'(bus_f.count_o[0]), 8);
        check("rst_cnt1",  int'(bus_f.count_o[1]), 8);
        check("rst_empty", int'(bus_f.empty_o),    3);
        check("rst_full",  int'(bus_f.full_o),     0);
        check("rst_err",   int'(bus_f.error_o),    0);

        // Fill channel 0
        drive(1'b0, 2'b01, 2'b01, 2'd0, 2'd0);
        for (int i = 0; i < 8; i++) cycle();
        check("fill_cnt0",  int'(bus_f.count_o[0]), 0);
        check("fill_full0", int'(bus_f.full_o[0]),  1);
        check("fill_cnt1",  int'(bus_f.count_o[1]), 8);

        // Overflow and stickiness
        cycle();
        check("ovf_cnt0", int'(bus_f.count_o[0]), 0);
        check("ovf_err0", int'(bus_f.error_o[0]), 1);
        drive(1'b0, 2'b00, 2'b00, 2'd2, 2'd0);
        cycle();
        check("ovf_sticky", int'(bus_f.error_o[0]), 1);
        check("ovf_yumi",   int'(bus_f.count_o[0]), 2);

        // Reset mid-traffic wins over a same-cycle enqueue
        drive(1'b1, 2'b01, 2'b01, 2'd0, 2'd0);
        cycle();
        check("midrst_cnt0", int'(bus_f.count_o[0]), 8);
        check("midrst_err",  int'(bus_f.error_o),    0);

        // Simultaneous enqueue and yumi of 2 at count 5
        drive(1'b0, 2'b01, 2'b01, 2'd0, 2'd0);
        for (int i = 0; i < 3; i++) cycle();
        check("sim_pre", int'(bus_f.count_o[0]), 5);
        drive(1'b0, 2'b01, 2'b01, 2'd2, 2'd0);
        cycle();
        check("sim_cnt0", int'(bus_f.count_o[0]), 6);
        drive(1'b0, 2'b01, 2'b01, 2'd1, 2'd0);
        cycle();
        check("sim_net0", int'(bus_f.count_o[0]), 6);

        // Used mode: underflow on ch0, illegal step on ch1
        drive(1'b1, 2'b00, 2'b00, 2'd0, 2'd0);
        cycle();
        drive(1'b0, 2'b11, 2'b11, 2'd0, 2'd0);
        cycle();
        drive(1'b0, 2'b10, 2'b10, 2'd0, 2'd0);
        cycle();
        check("u_pre0", int'(bus_u.count_o[0]), 1);
        check("u_pre1", int'(bus_u.count_o[1]), 2);
        drive(1'b0, 2'b00, 2'b00, 2'd2, 2'd3);
        cycle();
        check("unf_cnt0",  int'(bus_u.count_o[0]), 0);
        check("unf_err0",  int'(bus_u.error_o[0]), 1);
        check("bad_cnt1",  int'(bus_u.count_o[1]), 2);
        check("bad_err1",  int'(bus_u.error_o[1]), 1);

        // Randomized traffic with alternating fill/drain bias
        drive(1'b1, 2'b00, 2'b00, 2'd0, 2'd0);
        cycle();
        for (int i = 0; i < 2000; i++) begin
            bit fill_phase;
            fill_phase = ((i / 64) % 2) == 0;
            reset = ($urandom_range(0, 149) == 0);
            for (int c = 0; c < ch_lp; c++) begin
                int r;
                v[c]     = fill_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                ready[c] = ($urandom_range(0, 4) != 0);
                r        = $urandom_range(0, 39);
                if (r == 0)
                    yumi[c] = 2'd3;
                else if (fill_phase)
                    yumi[c] = 2'($urandom_range(0, 1));
                else
                    yumi[c] = 2'($urandom_range(0, 2));
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
